pcc_rx_ctrl: RTL and testbench
==============================

# pcc_rx_ctrl

Receive-side sequencer for the PCC router's local IP port. It classifies incoming flits as header, payload or cancel and tracks one circuit transfer from header to last payload flit. Payload is buffered in a 2-entry FIFO toward the local sink. The block drives the registered status pulses `PCC_ip_pack_o`, `PCC_ip_fail_o` and `PCC_ip_cancel_o`, and the level `PCC_ip_suspend_o`, back toward the router.

## Interface
- `DATAW`, 66: flit width. Bit DATAW-1 is the header flag; bits [DATAW-2:DATAW-3] are the type field, where 2'b11 means cancel.
- `LENW`, 8: payload-length field width, carried in header bits [LENW-1:0].
- `TMO`, 255: idle-cycle limit in STREAM before the transfer fails.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  **asynchronous, active-low** reset.
- `PCC_ip_data_i`  in  DATAW  incoming flit.
- `PCC_ip_stb_i`  in  1  flit valid.
- `PCC_ip_fwd_i`  in  1  flit is pass-through traffic; when 1 the flit is ignored entirely.
- `sink_data_o`  out  DATAW-3  payload bits [DATAW-4:0] of the FIFO head.
- `sink_valid_o`  out  1  FIFO non-empty.
- `sink_last_o`  out  1  FIFO head is the final payload flit.
- `sink_ready_i`  in  1  sink accepts the head (pop when valid&&ready).
- `PCC_ip_pack_o`  out  1  transfer-complete pulse.
- `PCC_ip_fail_o`  out  1  protocol-error pulse.
- `PCC_ip_cancel_o`  out  1  cancel-accepted pulse.
- `PCC_ip_suspend_o`  out  1  FIFO full; upstream must hold stb low.
- `busy_o`  out  1  state is not IDLE.

## Operation
- A flit is valid only when stb=1 and fwd=0. Valid flits are classified with this priority:
  - cancel: type field == 11.
  - header: bit DATAW-1 == 1.
  - payload: any other valid flit.
- States are IDLE, STREAM and DRAIN. Counters: `remaining` is LENW bits wide; `timer` is wide enough to hold TMO.
- IDLE:
  - header with LEN≠0: load remaining=LEN, clear timer, go to STREAM.
  - header with LEN=0: fail pulse, stay in IDLE.
  - payload or cancel: ignored, no pulse.
- STREAM:
  - payload: push to FIFO, decrement remaining, clear timer. When remaining reaches 0, tag the flit last and go to DRAIN.
  - no payload this cycle: increment timer. When timer reaches TMO: fail, flush FIFO, go to IDLE.
- DRAIN:
  - when the last-tagged flit pops: pack pulse, go to IDLE.
  - timer is not counted in DRAIN.
- Error cases, each producing fail, FIFO flush and a return to IDLE:
  - header in STREAM or DRAIN.
  - payload in DRAIN.
  - push while the FIFO holds 2 entries and no pop occurs that cycle (overflow).
- Cancel in STREAM or DRAIN: cancel pulse, flush, go to IDLE.
- Simultaneous events:
  - cancel overrides timeout and overflow.
  - a push and a pop in the same cycle are both performed; occupancy is unchanged.
  - a flush discards any pop in the same cycle.
- `remaining` never wraps: LEN=0 is rejected in IDLE.

## Timing
- Reset values: every output is 0, state is IDLE, FIFO is empty, counters are 0.
- `reset` asserted in mid-transfer clears everything immediately, with no pulse.
- All outputs are registered:
  - an event sampled at edge N produces a pulse that is high for exactly the cycle after N.
  - pulses never stretch. Back-to-back transfers can produce pack pulses on consecutive transfers.
- FIFO latency: a payload pushed at edge N shows `sink_valid_o`=1 after edge N.
  - with the sink always ready, throughput is 1 flit/cycle.
- `PCC_ip_suspend_o` = (occupancy == 2), taken after the edge.
- pack follows the edge that pops the last flit. A new header is accepted one cycle after pack.

## Structure
- The shared package `pcc_pkg` holds:
  - the state enum.
  - the flit-type constants: cancel = 2'b11, and the header bit index.
  - a classify function returning header, payload, cancel or none.
- Sub-module `pcc_rx_fifo2`: 2-entry FIFO with push, pop, flush, count, full and empty, carrying payload plus the last tag.

## Test plan
- Header LEN=3, then 3 payload flits on consecutive cycles, sink_ready=1 → 3 pops with `sink_last_o` on the third; pack high for one cycle one cycle after the last pop; busy_o returns to 0.
- Header LEN=4, sink_ready=0 after 2 pushes → suspend_o=1. Upstream holds off; raise ready → suspend clears, all 4 flits delivered in order, then pack.
- Header LEN=5, 2 payloads, then a cancel flit (type 11) → cancel pulse, FIFO empty, state IDLE, no fail or pack. A later header LEN=1 plus 1 payload completes normally.
- Header LEN=0 → fail pulse only. Header LEN=2, 1 payload, then TMO idle cycles → fail, flush.
- Payload pushed with FIFO full and sink_ready=0 → fail, flush. Flits with fwd=1 during STREAM → no effect on remaining or timer.
- Assert `reset` low mid-STREAM with 1 entry buffered → all outputs 0 asynchronously; after release, a header LEN=1 plus payload completes.

Source files
------------

// File: rtl/pcc_pkg.sv
// Shared definitions for the PCC receive path: controller states, flit-type
// constants and the flit classifier.
package pcc_pkg;

  localparam int unsigned PCC_DATAW = 66;
  localparam logic [1:0]  PCC_FTYPE_CANCEL = 2'b11;
  localparam int unsigned PCC_HDR_BIT = PCC_DATAW - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } pcc_state_e;

  typedef enum logic [1:0] {
    FLIT_NONE,
    FLIT_HDR,
    FLIT_PAYLOAD,
    FLIT_CANCEL
  } pcc_flit_e;

  function automatic int unsigned hdr_bit_idx(input int unsigned dataw);
    return dataw - 1;
  endfunction

  // Cancel wins over the header flag, so a cancel may carry either flag value.
  function automatic pcc_flit_e classify(input logic       flit_valid,
                                         input logic       hdr_bit,
                                         input logic [1:0] ftype);
    pcc_flit_e kind;
    kind = FLIT_NONE;
    if (flit_valid) begin
      if (ftype == PCC_FTYPE_CANCEL) kind = FLIT_CANCEL;
      else if (hdr_bit)              kind = FLIT_HDR;
      else                           kind = FLIT_PAYLOAD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/pcc_rx_ctrl_if.sv
// Payload stream from the receive controller toward the local sink.
interface pcc_rx_ctrl_if #(
  parameter int unsigned DW = 63
);
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/pcc_rx_fifo2.sv
// Two-entry payload FIFO with last tag; flush has priority over push and pop.
module pcc_rx_fifo2 #(
  parameter int unsigned W = 63
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop_req,
  input  logic         flush,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic [1:0]        last_q, last_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        count_q, count_d;
  logic              pop;
  logic              do_push;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head_data = mem_q[rd_q];
  assign head_last = last_q[rd_q];
  assign pop     = pop_req && !empty && !flush;
  assign do_push = push && !flush && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    last_d  = last_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (pop) rd_d = ~rd_q;
      if (do_push) begin
        mem_d[wr_q]  = push_data;
        last_d[wr_q] = push_last;
        wr_d         = ~wr_q;
      end
      case ({do_push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      last_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pcc_rx_ctrl.sv
// Receive-side sequencer for the PCC local IP port: tracks one circuit transfer
// from header to last payload and reports pack/fail/cancel back to the router.
module pcc_rx_ctrl
  import pcc_pkg::*;
#(
  parameter int unsigned DATAW = 66,
  parameter int unsigned LENW  = 8,
  parameter int unsigned TMO   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DATAW-1:0] PCC_ip_data_i,
  input  logic             PCC_ip_stb_i,
  input  logic             PCC_ip_fwd_i,
  pcc_rx_ctrl_if.master    sink,
  output logic             PCC_ip_pack_o,
  output logic             PCC_ip_fail_o,
  output logic             PCC_ip_cancel_o,
  output logic             PCC_ip_suspend_o,
  output logic             busy_o
);

  localparam int unsigned HDR_BIT = hdr_bit_idx(DATAW);
  localparam int unsigned PAYW    = DATAW - 3;
  localparam int unsigned TMRW    = $clog2(TMO + 1);

  pcc_state_e      state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [TMRW-1:0] timer_q, timer_d;
  logic [TMRW-1:0] timer_inc;
  logic            pack_q, pack_d;
  logic            fail_q, fail_d;
  logic            cancel_q, cancel_d;

  pcc_flit_e       kind;
  logic [LENW-1:0] hdr_len;
  logic            push, push_last, flush;
  logic            sink_pop;
  logic [PAYW-1:0] head_data;
  logic            head_last;
  logic [1:0]      fifo_count;
  logic            fifo_full, fifo_empty;

  assign kind = classify(PCC_ip_stb_i && !PCC_ip_fwd_i,
                         PCC_ip_data_i[HDR_BIT],
                         PCC_ip_data_i[DATAW-2:DATAW-3]);
  assign hdr_len   = PCC_ip_data_i[LENW-1:0];
  assign sink_pop  = !fifo_empty && sink.ready;
  assign timer_inc = timer_q + TMRW'(1);

  pcc_rx_fifo2 #(.W(PAYW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (PCC_ip_data_i[PAYW-1:0]),
    .push_last (push_last),
    .pop_req   (sink.ready),
    .flush     (flush),
    .head_data (head_data),
    .head_last (head_last),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timer_d   = timer_q;
    pack_d    = 1'b0;
    fail_d    = 1'b0;
    cancel_d  = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    flush     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (kind == FLIT_HDR) begin
          if (hdr_len != '0) begin
            rem_d   = hdr_len;
            timer_d = '0;
            state_d = ST_STREAM;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (kind == FLIT_CANCEL) begin
          cancel_d = 1'b1;
          flush    = 1'b1;
          state_d  = ST_IDLE;
        end else if (kind == FLIT_HDR) begin
          fail_d  = 1'b1;
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (kind == FLIT_PAYLOAD) begin
          // A push into a full FIFO is only legal when the head leaves this cycle.
          if (fifo_full && !sink_pop) begin
            fail_d  = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            push    = 1'b1;
            rem_d   = rem_q - LENW'(1);
            timer_d = '0;
            if (rem_q == LENW'(1)) begin
              push_last = 1'b1;
              state_d   = ST_DRAIN;
            end
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TMRW'(TMO)) begin
            timer_d = '0;
            fail_d  = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (kind == FLIT_CANCEL) begin
          cancel_d = 1'b1;
          flush    = 1'b1;
          state_d  = ST_IDLE;
        end else if (kind == FLIT_HDR || kind == FLIT_PAYLOAD) begin
          fail_d  = 1'b1;
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (sink_pop && head_last) begin
          pack_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      timer_q  <= '0;
      pack_q   <= 1'b0;
      fail_q   <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      timer_q  <= timer_d;
      pack_q   <= pack_d;
      fail_q   <= fail_d;
      cancel_q <= cancel_d;
    end
  end

  assign sink.data  = head_data;
  assign sink.valid = !fifo_empty;
  assign sink.last  = head_last && !fifo_empty;

  assign PCC_ip_pack_o    = pack_q;
  assign PCC_ip_fail_o    = fail_q;
  assign PCC_ip_cancel_o  = cancel_q;
  assign PCC_ip_suspend_o = (fifo_count == 2'd2);
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcc_rx_ctrl.sv
// Scoreboard bench for pcc_rx_ctrl: directed flits queue expected sink beats
// and status pulses; a negedge monitor pops and compares them as they appear.
module tb_pcc_rx_ctrl;

  localparam int unsigned DATAW = 66;
  localparam int unsigned TMO   = 255;

  typedef enum {EV_BEAT, EV_PACK, EV_FAIL, EV_CANCEL} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [62:0] data;
    logic        last;
  } ev_t;

  logic             clk;
  logic             reset;
  logic [DATAW-1:0] din;
  logic             stb;
  logic             fwd;
  logic             pack, fail, cancel, suspend, busy;

  int checks;
  int errors;
  ev_t exp_q[$];

  pcc_rx_ctrl_if #(.DW(DATAW-3)) sink_if ();

  pcc_rx_ctrl #(.DATAW(DATAW), .LENW(8), .TMO(TMO)) dut (
    .clk              (clk),
    .reset            (reset),
    .PCC_ip_data_i    (din),
    .PCC_ip_stb_i     (stb),
    .PCC_ip_fwd_i     (fwd),
    .sink             (sink_if.master),
    .PCC_ip_pack_o    (pack),
    .PCC_ip_fail_o    (fail),
    .PCC_ip_cancel_o  (cancel),
    .PCC_ip_suspend_o (suspend),
    .busy_o           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [65:0] hdr(input logic [7:0] len);
    return {1'b1, 2'b00, 55'd0, len};
  endfunction

  function automatic logic [65:0] pl(input logic [62:0] p);
    return {1'b0, 2'b00, p};
  endfunction

  function automatic logic [65:0] cxl();
    return {1'b0, 2'b11, 63'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_beat(input logic [62:0] p, input logic l);
    ev_t e;
    e.kind = EV_BEAT; e.data = p; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic exp_ev(input ev_kind_e k);
    ev_t e;
    e.kind = k; e.data = '0; e.last = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input ev_kind_e k, input logic [62:0] d, input logic l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual=%s/%0h/%0b required=none", k.name(), d, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_BEAT && (e.data !== d || e.last !== l))) begin
        errors++;
        $display("FAIL event actual=%s/%0h/%0b required=%s/%0h/%0b",
                 k.name(), d, l, e.kind.name(), e.data, e.last);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sink_if.valid && sink_if.ready) mon_ev(EV_BEAT, sink_if.data, sink_if.last);
    if (pack)   mon_ev(EV_PACK,   '0, 1'b0);
    if (fail)   mon_ev(EV_FAIL,   '0, 1'b0);
    if (cancel) mon_ev(EV_CANCEL, '0, 1'b0);
  end

  task automatic cyc(input logic [65:0] d, input logic s, input logic f);
    din = d; stb = s; fwd = f;
    @(posedge clk); #1;
    din = '0; stb = 1'b0; fwd = 1'b0;
  endtask

  task automatic send(input logic [65:0] d);
    cyc(d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [63:0] all_outs();
    return {sink_if.valid, sink_if.last, sink_if.data[55:0],
            pack, fail, cancel, suspend, busy, 1'b0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; din = '0; stb = 1'b0; fwd = 1'b0; sink_if.ready = 1'b0;
    #1;
    chk("reset_outputs", all_outs(), '0);
    chk("reset_data", 64'(sink_if.data), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);

    // LEN=3 streamed straight through
    sink_if.ready = 1'b1;
    exp_beat(63'h11, 1'b0); exp_beat(63'h12, 1'b0); exp_beat(63'h13, 1'b1);
    exp_ev(EV_PACK);
    send(hdr(8'd3));
    chk("busy_after_hdr", 64'(busy), 64'd1);
    send(pl(63'h11)); send(pl(63'h12)); send(pl(63'h13));
    idle(3);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // LEN=4 with backpressure
    sink_if.ready = 1'b0;
    exp_beat(63'h21, 1'b0); exp_beat(63'h22, 1'b0);
    exp_beat(63'h23, 1'b0); exp_beat(63'h24, 1'b1);
    exp_ev(EV_PACK);
    send(hdr(8'd4)); send(pl(63'h21)); send(pl(63'h22));
    chk("t2_suspend_full", 64'(suspend), 64'd1);
    idle(3);
    chk("t2_suspend_held", 64'(suspend), 64'd1);
    sink_if.ready = 1'b1;
    idle(1);
    chk("t2_suspend_clear", 64'(suspend), 64'd0);
    send(pl(63'h23)); send(pl(63'h24));
    idle(3);
    chk("t2_busy_done", 64'(busy), 64'd0);

    // Cancel mid-transfer, then a normal LEN=1 transfer
    sink_if.ready = 1'b0;
    exp_ev(EV_CANCEL);
    send(hdr(8'd5)); send(pl(63'h31)); send(pl(63'h32)); send(cxl());
    chk("t3_valid_flushed", 64'(sink_if.valid), 64'd0);
    chk("t3_busy_idle", 64'(busy), 64'd0);
    sink_if.ready = 1'b1;
    exp_beat(63'h33, 1'b1); exp_ev(EV_PACK);
    send(hdr(8'd1)); send(pl(63'h33));
    idle(3);

    // LEN=0 rejected; then timeout exactly at TMO idle cycles
    exp_ev(EV_FAIL);
    send(hdr(8'd0));
    chk("t4_len0_idle", 64'(busy), 64'd0);
    idle(2);
    sink_if.ready = 1'b0;
    send(hdr(8'd2)); send(pl(63'h41));
    idle(TMO - 1);
    chk("t4_before_tmo", 64'(busy), 64'd1);
    exp_ev(EV_FAIL);
    idle(1);
    chk("t4_after_tmo_busy", 64'(busy), 64'd0);
    chk("t4_after_tmo_valid", 64'(sink_if.valid), 64'd0);
    idle(2);

    // Overflow: third push into a full FIFO with no pop
    exp_ev(EV_FAIL);
    send(hdr(8'd4)); send(pl(63'h51)); send(pl(63'h52)); send(pl(63'h53));
    chk("t5_ovf_valid", 64'(sink_if.valid), 64'd0);
    chk("t5_ovf_busy", 64'(busy), 64'd0);
    idle(2);

    // Forwarded flits ignored during STREAM
    sink_if.ready = 1'b1;
    exp_beat(63'h61, 1'b0); exp_beat(63'h62, 1'b1); exp_ev(EV_PACK);
    send(hdr(8'd2)); send(pl(63'h61));
    cyc(hdr(8'd9), 1'b1, 1'b1);
    cyc(pl(63'h7F), 1'b1, 1'b1);
    cyc(cxl(), 1'b1, 1'b1);
    chk("t5_fwd_busy", 64'(busy), 64'd1);
    send(pl(63'h62));
    idle(3);
    chk("t5_fwd_done", 64'(busy), 64'd0);

    // Asynchronous reset mid-STREAM with one entry buffered
    sink_if.ready = 1'b0;
    send(hdr(8'd3)); send(pl(63'h71));
    chk("t6_one_buffered", 64'(sink_if.valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_reset", all_outs(), '0);
    @(posedge clk); #1;
    chk("t6_held_reset", all_outs(), '0);
    reset = 1'b1;
    sink_if.ready = 1'b1;
    exp_beat(63'h72, 1'b1); exp_ev(EV_PACK);
    exp_beat(63'h73, 1'b1); exp_ev(EV_PACK);
    send(hdr(8'd1)); send(pl(63'h72));
    idle(1);
    send(hdr(8'd1)); send(pl(63'h73));
    idle(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
